ram_req_ctrl: RTL



---
 rtl/ram_req_ctrl_pkg.sv | 23 ++
 rtl/ram_req_fifo.sv | 49 ++++
 rtl/ram_req_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/ram_req_ctrl_pkg.sv
// Shared types for the RAM request front end: request record, FSM states
// and the RAM geometry constants.
package ram_req_ctrl_pkg;

    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DATA_W = 4;
    localparam int RAM_QDEPTH = 2;

    typedef struct packed {
        logic                  we;
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] wdata;
    } ram_req_t;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_OE,
        RD_CAP
    } ctrl_state_e;

endpackage

// File: rtl/ram_req_fifo.sv
// Two-entry request FIFO; head entry is always visible on pop_data.
module ram_req_fifo
    import ram_req_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  ram_req_t   push_data,
    input  logic       pop,
    output ram_req_t   pop_data,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    ram_req_t mem [2];
    logic     wr_ptr;
    logic     rd_ptr;
    logic     do_push;
    logic     do_pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            // simultaneous push and pop leaves the occupancy unchanged
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// RAM request front end: queues read/write requests and sequences them onto
// the RAM cs/we/oe pins, returning read data as a one-cycle response pulse.
module ram_req_ctrl
    import ram_req_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int QDEPTH = RAM_QDEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    ctrl_state_e state;
    ctrl_state_e nxt;
    ram_req_t    in_req;
    ram_req_t    head;
    logic        push;
    logic        pop;
    logic        q_full;
    logic        q_empty;
    logic [1:0]  q_count;

    assign in_req    = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign req_ready = (q_count != 2'(QDEPTH));
    assign push      = req_valid && !q_full;

    ram_req_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_req),
        .pop       (pop),
        .pop_data  (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // IDLE, WR and RD_CAP all dispatch the queue head directly, so writes
    // stream one per cycle and reads one per three.
    always_comb begin
        nxt = state;
        pop = 1'b0;
        case (state)
            IDLE, WR, RD_CAP: begin
                if (!q_empty) begin
                    pop = 1'b1;
                    nxt = head.we ? WR : RD_ADDR;
                end else begin
                    nxt = IDLE;
                end
            end
            RD_ADDR: nxt = RD_OE;
            RD_OE:   nxt = RD_CAP;
            default: nxt = IDLE;
        endcase
    end

    // Pin outputs are registered from the next state so they are stable for
    // the whole cycle spent in that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_oe      <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_addr    <= '0;
        end else begin
            ram_cs    <= (nxt != IDLE);
            ram_we    <= (nxt == WR);
            ram_oe    <= (nxt == RD_OE) || (nxt == RD_CAP);
            rsp_valid <= (state == RD_CAP);
            if (pop)             ram_address <= head.addr;
            if (pop && head.we)  ram_data_in <= head.wdata;
            if (state == RD_CAP) begin
                rsp_rdata <= ram_data_out;
                rsp_addr  <= ram_address;
            end
        end
    end

endmodule
